plusarg_cfg_loader: RTL and testbench

Simulation/bring-up configuration sequencer. It takes a packed vector of configuration words, each normally driven by a plusarg_reader instance, and writes the enabled words in ascending index order to a target register port over a valid/ready handshake. Each write has a timeout so a dead target cannot hang the sequence. Completion and error status are reported to the test harness.

---
 rtl/plusarg_cfg_loader.sv | 135 +++++++++++++
 tb/tb_plusarg_cfg_loader.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plusarg_cfg_loader.sv
// Bring-up config sequencer: writes enabled cfg words in index order to a register port.
// Two cycles per write minimum (SCAN + WRITE); wr_valid holds until wr_ready or TIMEOUT cycles expire.
module plusarg_cfg_loader #(
  parameter int NUM_ENTRIES = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int ADDR_BASE   = 'h100,
  parameter int ADDR_STRIDE = 4,
  parameter int START_DELAY = 4,
  parameter int TIMEOUT     = 8
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [NUM_ENTRIES*DATA_WIDTH-1:0] cfg_data,
  input  logic [NUM_ENTRIES-1:0]            cfg_en,
  input  logic                              restart,
  output logic                              wr_valid,
  input  logic                              wr_ready,
  output logic [ADDR_WIDTH-1:0]             wr_addr,
  output logic [DATA_WIDTH-1:0]             wr_data,
  output logic                              busy,
  output logic                              done,
  output logic                              timeout_err,
  output logic [7:0]                        err_count
);

  localparam int IW  = $clog2(NUM_ENTRIES + 1);
  localparam int DCW = $clog2(START_DELAY + 1) + 1;
  localparam int WCW = $clog2(TIMEOUT + 1) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ENTRIES - 1);

  typedef enum logic [1:0] {S_DELAY, S_SCAN, S_WRITE, S_DONE} state_t;
  localparam state_t START_STATE = (START_DELAY == 0) ? S_SCAN : S_DELAY;

  state_t                  state;
  logic [IW-1:0]           idx;
  logic [DCW-1:0]          dcnt;
  logic [WCW-1:0]          wcnt;
  logic                    sel_en;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic                    wr_expired;
  logic                    wr_end;

  always_comb begin
    sel_en   = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (idx == IW'(i)) begin
        sel_en   = cfg_en[i];
        sel_data = cfg_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    // Arithmetic in ADDR_WIDTH bits gives the required modulo truncation for free.
    sel_addr = ADDR_WIDTH'(ADDR_BASE) + ADDR_WIDTH'(idx) * ADDR_WIDTH'(ADDR_STRIDE);
  end

  // Handshake on the last allowed cycle beats the timeout.
  assign wr_expired = (TIMEOUT > 0) && (wcnt == WCW'(TIMEOUT - 1)) && !wr_ready;
  assign wr_end     = wr_ready || wr_expired;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= START_STATE;
      idx         <= '0;
      dcnt        <= '0;
      wcnt        <= '0;
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      err_count   <= '0;
    end else begin
      case (state)
        S_DELAY: begin
          if (dcnt == DCW'(START_DELAY - 1)) begin
            state <= S_SCAN;
            dcnt  <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        S_SCAN: begin
          if (sel_en) begin
            wr_addr  <= sel_addr;
            wr_data  <= sel_data;
            wr_valid <= 1'b1;
            wcnt     <= '0;
            state    <= S_WRITE;
          end else if (idx == LAST_IDX) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_WRITE: begin
          if (wr_end) begin
            wr_valid <= 1'b0;
            if (wr_expired) begin
              timeout_err <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
            if (idx == LAST_IDX) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_SCAN;
            end
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_DONE: begin
          if (restart) begin
            state       <= START_STATE;
            idx         <= '0;
            dcnt        <= '0;
            done        <= 1'b0;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
            err_count   <= '0;
          end
        end
        default: state <= S_DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_plusarg_cfg_loader.sv
// Self-checking bench: directed scenarios plus random traffic, checked each cycle against a behavioural model.
module tb_plusarg_cfg_loader;

  localparam int N      = 4;
  localparam int DW     = 32;
  localparam int AW     = 12;
  localparam int BASE   = 'h100;
  localparam int STRIDE = 4;
  localparam int SD     = 4;
  localparam int TO     = 8;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [N*DW-1:0] cfg_data;
  logic [N-1:0]    cfg_en;
  logic            restart;
  logic            wr_valid;
  logic            wr_ready;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            busy;
  logic            done;
  logic            timeout_err;
  logic [7:0]      err_count;

  plusarg_cfg_loader #(
    .NUM_ENTRIES(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_BASE(BASE),
    .ADDR_STRIDE(STRIDE), .START_DELAY(SD), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .cfg_data(cfg_data), .cfg_en(cfg_en),
    .restart(restart), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .timeout_err(timeout_err), .err_count(err_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } hs_t;

  int            m_delay, m_pos, m_age, cyc;
  bit            m_wr;
  logic          exp_valid, exp_done, exp_terr;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  int            exp_errc;

  hs_t hs_q[$];
  int  fin_cyc, n_v, first_v, last_v;

  function void clear_log();
    hs_q.delete();
    fin_cyc = -1;
    n_v     = 0;
    first_v = -1;
    last_v  = -1;
  endfunction

  function void advance(input int now);
    if (m_pos == N - 1) begin
      exp_done = 1'b1;
      fin_cyc  = now + 1;
    end else begin
      m_pos++;
    end
  endfunction

  function void retire(input int now);
    m_wr      = 1'b0;
    exp_valid = 1'b0;
    advance(now);
  endfunction

  always @(posedge clock) begin : model
    int now;
    if (!reset_n) begin
      m_delay   = SD;
      m_pos     = 0;
      m_wr      = 1'b0;
      m_age     = 0;
      cyc       = 0;
      exp_valid = 1'b0;
      exp_addr  = '0;
      exp_data  = '0;
      exp_done  = 1'b0;
      exp_terr  = 1'b0;
      exp_errc  = 0;
    end else begin
      now = cyc;
      cyc++;
      if (exp_done) begin
        if (restart) begin
          exp_done = 1'b0;
          m_delay  = SD;
          m_pos    = 0;
          exp_terr = 1'b0;
          exp_errc = 0;
        end
      end else if (m_wr) begin
        n_v++;
        if (first_v < 0) first_v = now;
        last_v = now;
        m_age++;
        if (wr_ready) begin
          hs_q.push_back('{now, exp_addr, exp_data});
          retire(now);
        end else if (TO > 0 && m_age == TO) begin
          exp_terr = 1'b1;
          if (exp_errc < 255) exp_errc++;
          retire(now);
        end
      end else if (m_delay > 0) begin
        m_delay--;
      end else if (cfg_en[m_pos]) begin
        m_wr      = 1'b1;
        m_age     = 0;
        exp_valid = 1'b1;
        exp_addr  = AW'((BASE + m_pos * STRIDE) % (1 << AW));
        exp_data  = cfg_data[m_pos*DW +: DW];
      end else begin
        advance(now);
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("wr_valid", wr_valid, exp_valid);
      check("wr_addr", wr_addr, exp_addr);
      check("wr_data", wr_data, exp_data);
      check("done", done, exp_done);
      check("busy", busy, !exp_done);
      check("timeout_err", timeout_err, exp_terr);
      check("err_count", err_count, 64'(exp_errc));
    end
  end

  // ---------------- stimulus ----------------
  int rmode = 0;   // 0 ready=1, 1 ready=0, 2 ready after thr valid cycles, 3 random
  int thr   = 4;
  int vrun  = 0;
  bit rnd   = 0;
  bit dead  = 0;

  task automatic tick();
    @(negedge clock);
    vrun = wr_valid ? vrun + 1 : 0;
    if (rnd) begin
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < N; i++) cfg_data[i*DW +: DW] = $urandom;
      if ($urandom_range(0, 5) == 0) cfg_en = N'($urandom_range(0, (1 << N) - 1));
      restart = ($urandom_range(0, 9) == 0);
      reset_n = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 99) == 0) dead = !dead;
    end
    case (rmode)
      0:       wr_ready = 1'b1;
      1:       wr_ready = 1'b0;
      2:       wr_ready = (vrun >= thr);
      default: wr_ready = dead ? 1'b0 : 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) tick();
    reset_n = 1'b1;
    clear_log();
  endtask

  task automatic wait_done(input int budget, input string nm);
    int k = 0;
    while (!exp_done && k < budget) begin
      tick();
      k++;
    end
    check(nm, exp_done, 1'b1);
  endtask

  initial begin
    reset_n  = 1'b0;
    restart  = 1'b0;
    wr_ready = 1'b1;
    cfg_en   = 4'b1111;
    cfg_data = {32'hD, 32'hC, 32'hB, 32'hA};
    clear_log();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    check("rst_valid", wr_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_errc", err_count, 8'd0);

    // All entries, target always ready.
    wait_done(100, "t1_done");
    check("t1_nhs", hs_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < hs_q.size()) begin
        check("t1_hs_cyc", hs_q[i].cyc, 5 + 2 * i);
        check("t1_hs_addr", hs_q[i].addr, 'h100 + 4 * i);
        check("t1_hs_data", hs_q[i].data, 'hA + i);
      end
    end
    check("t1_fin_cyc", fin_cyc, 12);
    check("t1_errc", err_count, 8'd0);

    // Sparse enables.
    cfg_en = 4'b1010;
    do_reset(1);
    wait_done(100, "t2_done");
    check("t2_nhs", hs_q.size(), 2);
    if (hs_q.size() == 2) begin
      check("t2_cyc0", hs_q[0].cyc, 6);
      check("t2_addr0", hs_q[0].addr, 'h104);
      check("t2_addr1", hs_q[1].addr, 'h10C);
      check("t2_data1", hs_q[1].data, 'hD);
    end

    // Dead target: single write times out.
    cfg_en = 4'b0001;
    rmode  = 1;
    do_reset(1);
    wait_done(100, "t3_done");
    check("t3_nvalid", n_v, 8);
    check("t3_first_v", first_v, 5);
    check("t3_last_v", last_v, 12);
    check("t3_fin_cyc", fin_cyc, 16);
    check("t3_terr", timeout_err, 1'b1);
    check("t3_errc", err_count, 8'd1);
    check("t3_nhs", hs_q.size(), 0);

    // Restart from DONE clears status; a later restart during WRITE is ignored.
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("t6_done_clr", done, 1'b0);
    check("t6_errc_clr", err_count, 8'd0);
    check("t6_terr_clr", timeout_err, 1'b0);
    check("t6_busy", busy, 1'b1);
    cfg_en = 4'b1111;
    rmode  = 0;
    clear_log();
    begin
      int k = 0;
      while (!wr_valid && k < 50) begin
        tick();
        k++;
      end
      check("t6_found_write", wr_valid, 1'b1);
    end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    wait_done(100, "t6_done");
    check("t6_nhs", hs_q.size(), 4);

    // Backpressure: ready after 3 stalls, then only on the last allowed cycle.
    rmode = 2;
    thr   = 4;
    do_reset(1);
    wait_done(200, "t4a_done");
    check("t4a_nhs", hs_q.size(), 4);
    if (hs_q.size() > 0) check("t4a_cyc0", hs_q[0].cyc, 8);
    check("t4a_errc", err_count, 8'd0);
    thr = 8;
    do_reset(1);
    wait_done(200, "t4b_done");
    check("t4b_nhs", hs_q.size(), 4);
    if (hs_q.size() > 0) check("t4b_cyc0", hs_q[0].cyc, 12);
    check("t4b_terr", timeout_err, 1'b0);

    // Reset pulse during the idx 2 write.
    rmode = 0;
    do_reset(1);
    begin
      int k = 0;
      while (!(wr_valid && wr_addr == 12'h108) && k < 50) begin
        tick();
        k++;
      end
      check("t5_found_idx2", wr_addr, 12'h108);
    end
    reset_n = 1'b0;
    tick();
    check("t5_valid", wr_valid, 1'b0);
    check("t5_addr", wr_addr, 12'h000);
    check("t5_data", wr_data, 32'h0);
    check("t5_busy", busy, 1'b1);
    reset_n = 1'b1;
    clear_log();
    wait_done(100, "t5_done");
    check("t5_nhs", hs_q.size(), 4);
    if (hs_q.size() > 0) check("t5_addr0", hs_q[0].addr, 'h100);

    // Random traffic, restarts, resets and config churn.
    rmode = 3;
    rnd   = 1;
    repeat (4000) tick();
    rnd     = 0;
    restart = 1'b0;
    reset_n = 1'b1;
    rmode   = 0;
    wait_done(200, "rnd_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
